// File: rtl/alu_stream_unit.sv
// alu_stream_unit: handshaked N-bit ALU with in-order result FIFO (ALU_SAT_EN saturates add/sub)
module alu_stream_unit #(
   parameter int N = 4,
   parameter logic [1:0] OPCODE = 2'b00,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in0,
   input  logic [N-1:0] in1,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out,
   output logic [15:0]  done_cnt
);
   localparam int AW = $clog2(DEPTH);
   logic [N-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0] count;
   logic rdy_en, push, pop;
   logic [N:0] sum, diff;
   logic [N-1:0] add_r, sub_r, res;
   always_comb begin
      sum = {1'b0, in0} + {1'b0, in1};
      diff = {1'b0, in0} - {1'b0, in1};
`ifdef ALU_SAT_EN
      add_r = sum[N] ? '1 : sum[N-1:0];
      sub_r = diff[N] ? '0 : diff[N-1:0];
`else
      add_r = sum[N-1:0];
      sub_r = diff[N-1:0];
`endif
      res = OPCODE == 2'b00 ? add_r : OPCODE == 2'b01 ? sub_r : OPCODE == 2'b10 ? (in0 & in1) : (in0 | in1);
   end
   assign in_ready = rdy_en & (count != (AW+1)'(DEPTH));
   assign out_valid = count != '0;
   assign out = mem[rd_ptr];
   assign push = in_valid & in_ready;
   assign pop = out_valid & out_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en <= 1'b0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         done_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (push) begin
            mem[wr_ptr] <= res;
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            done_cnt <= done_cnt + 16'd1;
         end
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule
